// File: rtl/rom_dump_sequencer.sv
// Full-dump read-out sequencer for 556PT5/556PT4 ROMs: steps every address,
// waits the access time, captures the data word and offers {address, data} over valid/ready.
module rom_dump_sequencer #(
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDRESS_WIDTH = 9,
    parameter int         ACCESS_CYCLES = 4,
    parameter logic [3:0] READ_OP       = 4'b1100,
    parameter logic [3:0] IDLE_OP       = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic [3:0]               rom_operation,
    input  logic [DATA_WIDTH-1:0]    rom_data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic                     busy,
    output logic                     done
);

    // state   | meaning
    // IDLE    | not dumping, chip lines at IDLE_OP
    // SETUP   | address presented, access timer loaded
    // WAIT    | access timer counting down to zero
    // CAPTURE | sample chip data into the output register
    // OUTPUT  | word offered to the host until accepted
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_OUTPUT, S_DONE
    } state_t;

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    // One extra bit keeps the terminal-address compare exact without wrap.
    localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = {1'b0, {ADDRESS_WIDTH{1'b1}}};

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH:0]   addr_q, addr_d;
    logic [CNT_W-1:0]         wait_q, wait_d;
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] oaddr_q, oaddr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wait_d        = wait_q;
        valid_d       = valid_q;
        data_d        = data_q;
        oaddr_d       = oaddr_q;
        rom_operation = IDLE_OP;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETUP;
                    addr_d  = '0;
                end
            end
            S_SETUP: begin
                rom_operation = READ_OP;
                wait_d        = WAIT_LOAD;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                rom_operation = READ_OP;
                if (wait_q == '0) state_d = S_CAPTURE;
                else              wait_d  = wait_q - 1'b1;
            end
            S_CAPTURE: begin
                rom_operation = READ_OP;
                data_d        = rom_data_in;
                oaddr_d       = addr_q[ADDRESS_WIDTH-1:0];
                valid_d       = 1'b1;
                state_d       = S_OUTPUT;
            end
            S_OUTPUT: begin
                rom_operation = READ_OP;
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort freezes the address lines and drops the offered word.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            addr_d  = addr_q;
            data_d  = data_q;
            oaddr_d = oaddr_q;
        end
    end

    assign rom_address = addr_q[ADDRESS_WIDTH-1:0];
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_address = oaddr_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Bench for rom_dump_sequencer: two configurations, slow-settling ROM models,
// and a dump-level model of word order, timing, stalls, abort and reset.
module tb_rom_dump_sequencer;

    localparam logic [3:0] READ_OP = 4'b1100;
    localparam logic [3:0] IDLE_OP = 4'b0000;

    function automatic int aw_of(input int i); return (i == 0) ? 3 : 8; endfunction
    function automatic int dw_of(input int i); return (i == 0) ? 8 : 4; endfunction
    function automatic int ac_of(input int i); return (i == 0) ? 4 : 1; endfunction
    function automatic int rom_val(input int i, input int a);
        return (a ^ 'hA5) & ((1 << dw_of(i)) - 1);
    endfunction

    logic clk = 1'b0;
    logic reset_n;
    logic start_r[2];
    logic abort_r[2];
    logic ready_r[2];

    logic [15:0] rom_a[2];
    logic [15:0] oaddr_o[2];
    logic [7:0]  data_o[2];
    logic [3:0]  op_o[2];
    logic        valid_o[2];
    logic        busy_o[2];
    logic        done_o[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int AW = aw_of(g);
        localparam int DW = dw_of(g);
        localparam int AC = ac_of(g);
        logic [AW-1:0] ra, oa;
        logic [DW-1:0] rd, od;
        logic [3:0]    op;
        logic          v, b, d;
        logic [AW-1:0] last;
        int            age = 0;

        rom_dump_sequencer #(
            .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ACCESS_CYCLES(AC),
            .READ_OP(READ_OP), .IDLE_OP(IDLE_OP)
        ) dut (
            .clk(clk), .reset_n(reset_n), .start(start_r[g]), .abort(abort_r[g]),
            .rom_address(ra), .rom_operation(op), .rom_data_in(rd),
            .out_valid(v), .out_ready(ready_r[g]), .out_data(od),
            .out_address(oa), .busy(b), .done(d)
        );

        // Chip model: data only becomes correct ACCESS_CYCLES-1 cycles after an address change.
        always @(negedge clk) begin
            if (ra !== last) begin
                last <= ra;
                age  <= 0;
            end else if (age < 1000) begin
                age <= age + 1;
            end
        end
        assign rd = (age >= AC - 1) ? DW'(rom_val(g, int'(ra))) : ~DW'(rom_val(g, int'(ra)));

        assign rom_a[g]   = 16'(ra);
        assign oaddr_o[g] = 16'(oa);
        assign data_o[g]  = 8'(od);
        assign op_o[g]    = op;
        assign valid_o[g] = v;
        assign busy_o[g]  = b;
        assign done_o[g]  = d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input int i);
        chk("rst_rom_addr", 32'(rom_a[i]), 0);
        chk("rst_op", 32'(op_o[i]), 32'(IDLE_OP));
        chk("rst_valid", 32'(valid_o[i]), 0);
        chk("rst_data", 32'(data_o[i]), 0);
        chk("rst_oaddr", 32'(oaddr_o[i]), 0);
        chk("rst_busy", 32'(busy_o[i]), 0);
        chk("rst_done", 32'(done_o[i]), 0);
    endtask

    // mode 0: ready always; 1: 10-cycle stall on word 2; 2: random ready.
    // abort_addr / glitch_addr < 0 disable the abort and the in-OUTPUT start pulse.
    task automatic dump(input int i, input int mode, input int abort_addr, input int glitch_addr);
        int ac = ac_of(i);
        int n = 1 << aw_of(i);
        int exp_addr = 0;
        int rise_due = ac + 3;
        int setup_c = 1;
        int done_c = -1;
        int abort_c = -1;
        int stall = 0;
        bit seen = 1'b0;
        bit finished = 1'b0;
        @(negedge clk);
        start_r[i] = 1'b1;
        ready_r[i] = 1'b1;
        for (int c = 1; c < 20000 && !finished; c++) begin
            @(negedge clk);
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
            if (abort_c >= 0) begin
                chk("abort_busy", 32'(busy_o[i]), 0);
                chk("abort_valid", 32'(valid_o[i]), 0);
                chk("abort_op", 32'(op_o[i]), 32'(IDLE_OP));
                chk("abort_done", 32'(done_o[i]), 0);
                chk("abort_addr_hold", 32'(rom_a[i]), 32'(exp_addr));
                finished = 1'b1;
            end else if (done_c >= 0) begin
                if (c == done_c) begin
                    chk("done_pulse", 32'(done_o[i]), 1);
                    chk("done_busy", 32'(busy_o[i]), 1);
                end else begin
                    chk("done_clear", 32'(done_o[i]), 0);
                    chk("end_busy", 32'(busy_o[i]), 0);
                    chk("end_op", 32'(op_o[i]), 32'(IDLE_OP));
                    chk("end_valid", 32'(valid_o[i]), 0);
                    finished = 1'b1;
                end
            end else begin
                chk("busy", 32'(busy_o[i]), 1);
                chk("done_early", 32'(done_o[i]), 0);
                chk("op_read", 32'(op_o[i]), 32'(READ_OP));
                chk("rom_addr", 32'(rom_a[i]), 32'(exp_addr));
                case (mode)
                    0:       ready_r[i] = 1'b1;
                    1:       ready_r[i] = !(exp_addr == 2 && stall < 10);
                    default: ready_r[i] = ($urandom_range(0, 2) != 0);
                endcase
                if (valid_o[i]) begin
                    if (!seen) begin
                        chk("valid_rise_cycle", 32'(c), 32'(rise_due));
                        seen = 1'b1;
                        if (exp_addr == glitch_addr) start_r[i] = 1'b1;
                    end
                    chk("out_addr", 32'(oaddr_o[i]), 32'(exp_addr));
                    chk("out_data", 32'(data_o[i]), 32'(rom_val(i, exp_addr)));
                    if (exp_addr == 2) stall++;
                    if (ready_r[i]) begin
                        if (exp_addr == n - 1) begin
                            done_c = c + 1;
                        end else begin
                            exp_addr++;
                            rise_due = c + ac + 3;
                            setup_c = c + 1;
                            seen = 1'b0;
                        end
                    end
                end else begin
                    chk("valid_late", 32'(c < rise_due), 1);
                    if (exp_addr == abort_addr && c == setup_c + 1) begin
                        abort_r[i] = 1'b1;
                        abort_c = c;
                    end
                end
            end
        end
        chk("dump_finished", 32'(finished), 1);
        start_r[i] = 1'b0;
        abort_r[i] = 1'b0;
        ready_r[i] = 1'b1;
    endtask

    task automatic start_abort_idle(input int i);
        @(negedge clk);
        start_r[i] = 1'b1;
        abort_r[i] = 1'b1;
        @(negedge clk);
        start_r[i] = 1'b0;
        abort_r[i] = 1'b0;
        chk("sa_busy", 32'(busy_o[i]), 0);
        chk("sa_op", 32'(op_o[i]), 32'(IDLE_OP));
        repeat (3) @(negedge clk);
        chk("sa_busy_later", 32'(busy_o[i]), 0);
    endtask

    task automatic reset_in_output(input int i);
        int k;
        @(negedge clk);
        start_r[i] = 1'b1;
        ready_r[i] = 1'b0;
        @(negedge clk);
        start_r[i] = 1'b0;
        for (k = 0; k < 50 && !valid_o[i]; k++) @(negedge clk);
        chk("rio_reached_output", 32'(valid_o[i]), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset(i);
        reset_n = 1'b1;
        ready_r[i] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rio_stays_idle", 32'(busy_o[i]), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            abort_r[i] = 1'b0;
            ready_r[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        reset_n = 1'b1;
        @(negedge clk);

        dump(0, 0, -1, -1);
        dump(0, 1, -1, -1);
        dump(0, 0, 5, -1);
        dump(0, 0, -1, 3);
        start_abort_idle(0);
        reset_in_output(0);
        dump(0, 2, -1, -1);
        dump(1, 0, -1, -1);
        dump(1, 2, -1, 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
